// File: rtl/range_cmd_tx.sv
// range_cmd_tx
//   Command-frame encoder and 8N1 UART transmitter for the laser ranging
//   module. An accepted request is packed into a 6-byte frame
//   (HEADER, ADDR, CmdCode, CmdArg[15:8], CmdArg[7:0], CHK), which is then
//   shifted out on Tx, LSB first, with no gap between bytes.
//
//   Handshake: a request is accepted on any rising edge where CmdEn=1 and
//   Busy=0. CmdCode/CmdArg are sampled only on that edge. CmdEn while Busy=1
//   is dropped (not queued). Busy stays high until the frame ends; TxDone
//   pulses for one cycle as Busy falls, and a new request may be accepted in
//   that same cycle.
//
// Ports
//   Clk      system clock, rising edge
//   RstN     asynchronous active-low reset
//   CmdEn    command request (single-cycle pulse is enough)
//   CmdCode  command byte
//   CmdArg   16-bit command argument
//   Busy     high from acceptance until the frame completes
//   TxDone   one-cycle pulse after the last stop bit
//   Tx       serial output, registered, idle high
//   DbgState current FSM state (0 idle, 1 start, 2 data, 3 stop)
module range_cmd_tx #(
    parameter int          BAUD_DIV = 434,
    parameter logic [7:0]  HEADER   = 8'hAA,
    parameter logic [7:0]  ADDR     = 8'h80
) (
    input  logic        Clk,
    input  logic        RstN,
    input  logic        CmdEn,
    input  logic [7:0]  CmdCode,
    input  logic [15:0] CmdArg,
    output logic        Busy,
    output logic        TxDone,
    output logic        Tx,
    output logic [1:0]  DbgState
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] BAUD_MAX = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] BAUD_ONE = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [2:0]      byte_q, byte_d;
    logic [47:0]     frame_q, frame_d;
    logic            tx_q, tx_d;
    logic            done_q, done_d;

    logic [7:0]      chk;
    logic [7:0]      cur_byte;
    logic            bit_end;

    // Truncated 8-bit sum; HEADER is deliberately not part of it.
    assign chk      = ADDR + CmdCode + CmdArg[15:8] + CmdArg[7:0];
    // Byte 0 lives in frame_q[7:0], byte 5 in frame_q[47:40].
    assign cur_byte = frame_q[{byte_q, 3'b000} +: 8];
    assign bit_end  = (baud_q == BAUD_MAX);

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            frame_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            frame_q <= frame_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    // tx_d is the line level for the *next* state, so Tx changes on the very
    // edge where the state changes and stays a pure flop output.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        frame_d = frame_q;
        tx_d    = tx_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                bit_d  = '0;
                byte_d = '0;
                if (CmdEn) begin
                    frame_d = {chk, CmdArg[7:0], CmdArg[15:8], CmdCode, ADDR, HEADER};
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end

            S_START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                    tx_d    = cur_byte[0];
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = cur_byte[bit_q + 3'd1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end

            S_STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    bit_d  = '0;
                    if (byte_q == 3'd5) begin
                        byte_d  = '0;
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        byte_d  = byte_q + 3'd1;
                        state_d = S_START;
                        tx_d    = 1'b0;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end

            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign Busy     = (state_q != S_IDLE);
    assign TxDone   = done_q;
    assign Tx       = tx_q;
    assign DbgState = state_q;

endmodule
